sd_clk_gen: RTL and testbench

Parametrised SD clock generator for the SD subsystem: produces the SD card clock pin plus one-cycle rising/falling edge strobes consumed by the command and data engines. It generalises the fixed clock stage with a run-time divider of configurable width, a glitch-free hold mechanism driven by the data path (FIFO full/empty), and a counted burst mode that emits an exact number of clock cycles, used for the card-init clocks and for Ncc/Nwr gaps.

---
 rtl/sd_clk_gen_pkg.sv | 16 +
 rtl/sd_clk_gen.sv | 130 +++++++++++++
 tb/tb_sd_clk_gen.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_clk_gen_pkg.sv
// Shared constants for the SD clock generator: system clock rate and the
// divider settings the control block programs for each card speed mode.
package sd_clk_gen_pkg;

    localparam int unsigned SYS_CLK_HZ = 100_000_000;

    // Smallest divider whose SD clock does not exceed the target frequency.
    function automatic int unsigned div_for_hz(input int unsigned hz);
        return (SYS_CLK_HZ + 2 * hz - 1) / (2 * hz) - 1;
    endfunction

    localparam int unsigned DIV_INIT          = div_for_hz(400_000);
    localparam int unsigned DIV_DEFAULT_SPEED = div_for_hz(25_000_000);
    localparam int unsigned DIV_HIGH_SPEED    = div_for_hz(50_000_000);

endpackage

// File: rtl/sd_clk_gen.sv
// SD card clock generator: run-time divider, glitch-free hold that stretches
// the low phase, and a counted burst mode emitting an exact number of cycles.
module sd_clk_gen
    import sd_clk_gen_pkg::*;
#(
    parameter int DIV_WIDTH = 8,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] divider,
    input  logic                 enable,
    input  logic                 hold,
    input  logic                 burst_start,
    input  logic [CNT_WIDTH-1:0] burst_cycles,
    output logic                 burst_busy,
    output logic                 burst_done,
    output logic                 running,
    output logic                 sd_clk_rising,
    output logic                 sd_clk_falling,
    output logic                 sd_clk
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t               state, state_next;
    logic [DIV_WIDTH-1:0] cnt, cnt_next;
    logic [CNT_WIDTH-1:0] remaining, remaining_next;
    logic                 busy_next, done_next;
    logic                 clk_next, rise_next, fall_next;
    logic                 run_req, fall_evt;

    assign run_req  = (enable | burst_busy) & ~hold;
    assign fall_evt = (state == HIGH) && (cnt == '0);

    // Burst bookkeeping; busy_next is also the post-update state the HIGH
    // phase uses to decide whether the clock keeps running after its fall.
    always_comb begin
        busy_next      = burst_busy;
        remaining_next = remaining;
        done_next      = 1'b0;
        if (burst_start && !burst_busy) begin
            if (burst_cycles == '0) begin
                done_next = 1'b1;
            end else begin
                busy_next      = 1'b1;
                remaining_next = burst_cycles;
            end
        end else if (burst_busy && fall_evt) begin
            remaining_next = remaining - CNT_WIDTH'(1);
            if (remaining == CNT_WIDTH'(1)) begin
                busy_next = 1'b0;
                done_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clk_next   = sd_clk;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state)
            IDLE: begin
                clk_next = 1'b0;
                if (run_req) begin
                    cnt_next   = divider;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (!run_req) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (cnt == '0) begin
                    clk_next   = 1'b1;
                    rise_next  = 1'b1;
                    cnt_next   = divider;
                    state_next = HIGH;
                end else begin
                    cnt_next = cnt - DIV_WIDTH'(1);
                end
            end
            HIGH: begin
                // The high phase always completes so the card never sees a runt pulse.
                if (cnt == '0) begin
                    clk_next   = 1'b0;
                    fall_next  = 1'b1;
                    cnt_next   = divider;
                    state_next = ((enable | busy_next) & ~hold) ? LOW : IDLE;
                end else begin
                    cnt_next = cnt - DIV_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            sd_clk         <= 1'b0;
            sd_clk_rising  <= 1'b0;
            sd_clk_falling <= 1'b0;
            running        <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            sd_clk         <= clk_next;
            sd_clk_rising  <= rise_next;
            sd_clk_falling <= fall_next;
            running        <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            remaining  <= '0;
            burst_busy <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            remaining  <= remaining_next;
            burst_busy <= busy_next;
            burst_done <= done_next;
        end
    end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Scoreboard bench for sd_clk_gen: a phase-age reference model predicts the
// outputs of every cycle; a monitor compares them on the falling clock edge.
module tb_sd_clk_gen;
    import sd_clk_gen_pkg::*;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] divider;
    logic          enable, hold, burst_start;
    logic [CW-1:0] burst_cycles;
    logic          burst_busy, burst_done, running;
    logic          sd_clk_rising, sd_clk_falling, sd_clk;

    sd_clk_gen #(.DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .divider        (divider),
        .enable         (enable),
        .hold           (hold),
        .burst_start    (burst_start),
        .burst_cycles   (burst_cycles),
        .burst_busy     (burst_busy),
        .burst_done     (burst_done),
        .running        (running),
        .sd_clk_rising  (sd_clk_rising),
        .sd_clk_falling (sd_clk_falling),
        .sd_clk         (sd_clk)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic done;
        logic run;
        logic rise;
        logic fall;
        logic sclk;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_rise = 0, n_fall = 0, n_done = 0, n_busy = 0, n_edges_any = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the visible clock level plus how long the current
    // phase has been shown, against a length fixed when the phase began.
    bit m_active, m_level, m_busy, m_done, m_rise, m_fall;
    int m_age, m_plen, m_rem;

    task automatic model_step();
        bit rr, nb, nd, fall_now;
        int nr;
        exp_t e;
        if (reset) begin
            m_active = 0; m_level = 0; m_busy = 0; m_done = 0;
            m_rise = 0; m_fall = 0; m_age = 0; m_plen = 0; m_rem = 0;
        end else begin
            rr       = (enable || m_busy) && !hold;
            fall_now = m_active && m_level && (m_age == m_plen);
            nb = m_busy; nr = m_rem; nd = 0;
            if (burst_start && !m_busy) begin
                if (burst_cycles == 0) nd = 1;
                else begin nb = 1; nr = int'(burst_cycles); end
            end else if (m_busy && fall_now) begin
                nr = nr - 1;
                if (nr == 0) begin nb = 0; nd = 1; end
            end
            m_rise = 0; m_fall = 0;
            if (!m_active) begin
                if (rr) begin
                    m_active = 1; m_level = 0; m_age = 1; m_plen = int'(divider) + 1;
                end
            end else if (!m_level) begin
                if (!rr) m_active = 0;
                else if (m_age == m_plen) begin
                    m_level = 1; m_rise = 1; m_age = 1; m_plen = int'(divider) + 1;
                end else m_age++;
            end else begin
                if (fall_now) begin
                    m_level = 0; m_fall = 1; m_age = 1; m_plen = int'(divider) + 1;
                    m_active = (enable || nb) && !hold;
                end else m_age++;
            end
            m_busy = nb; m_rem = nr; m_done = nd;
        end
        e.cyc = cyc + 1;
        e.o   = '{busy: m_busy, done: m_done, run: m_active,
                  rise: m_rise, fall: m_fall, sclk: m_level};
        q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: compares the DUT against the queued prediction for this cycle.
    initial begin
        obs_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            act = '{busy: burst_busy, done: burst_done, run: running,
                    rise: sd_clk_rising, fall: sd_clk_falling, sclk: sd_clk};
            if (!reset) begin
                n_rise += int'(sd_clk_rising);
                n_fall += int'(sd_clk_falling);
                n_done += int'(burst_done);
                n_busy += int'(burst_busy);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                vectors++;
                if (act !== e.o) begin
                    miscompares++;
                    $display("FAIL out cyc=%0d busy/done/run/rise/fall/clk got %b required %b",
                             cyc, act, e.o);
                end
            end
        end
    end

    task automatic clear_counts();
        @(negedge clk);
        n_rise = 0; n_fall = 0; n_done = 0; n_busy = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; divider = '0; enable = 0; hold = 0;
        burst_start = 0; burst_cycles = '0;
        ticks(3);
        reset = 0;
        ticks(3);

        // divider 0: clk/2
        divider = DW'(DIV_HIGH_SPEED); enable = 1;
        ticks(12);
        enable = 0;
        ticks(6);

        // divider 3: period 8, then stop
        divider = 8'd3; enable = 1;
        ticks(40);
        enable = 0;
        ticks(12);

        // divider 1 with hold pulses in both phases
        divider = DW'(DIV_DEFAULT_SPEED); enable = 1;
        ticks(7);
        hold = 1; ticks(5); hold = 0;
        ticks(6);
        hold = 1; ticks(1); hold = 0;
        ticks(7);
        hold = 1; ticks(2); hold = 0;
        ticks(8);

        // divider 1 -> 5 mid low phase
        divider = 8'd1;
        ticks(3);
        divider = 8'd5;
        ticks(30);
        enable = 0;
        ticks(16);

        // 74-cycle burst with an ignored second start
        clear_counts();
        divider = 8'd2; burst_cycles = 8'd74; burst_start = 1;
        tick();
        burst_start = 0;
        ticks(20);
        burst_cycles = 8'd5; burst_start = 1;
        tick();
        burst_start = 0;
        ticks(470);
        @(negedge clk);
        check("burst74_rises", n_rise, 74);
        check("burst74_falls", n_fall, 74);
        check("burst74_done", n_done, 1);
        check("burst74_idle_after", int'(running), 0);
        #1;

        // zero-length burst
        clear_counts();
        burst_cycles = 8'd0; burst_start = 1;
        tick();
        burst_start = 0;
        ticks(6);
        @(negedge clk);
        check("burst0_done", n_done, 1);
        check("burst0_busy_cycles", n_busy, 0);
        check("burst0_edges", n_rise + n_fall, 0);
        #1;

        // reset mid-burst
        clear_counts();
        burst_cycles = 8'd10; burst_start = 1;
        tick();
        burst_start = 0;
        ticks(15);
        reset = 1;
        tick();
        reset = 0;
        ticks(40);
        @(negedge clk);
        check("reset_burst_no_done", n_done, 0);
        #1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) divider = DW'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) enable = ~enable;
            hold         = ($urandom_range(0, 9) == 0);
            burst_start  = ($urandom_range(0, 29) == 0);
            burst_cycles = CW'($urandom_range(0, 6));
            reset        = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 0; burst_start = 0; enable = 0; hold = 0;
        ticks(60);
        @(negedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
